// File: rtl/p08_pov_sched.sv
// p08_pov_sched -- frame-synchronous POV update scheduler.
//
// Watches VGA vsync and the raytracer busy flag and issues a one-cycle
// o_load_if_ready strobe only when the POV vectors can change without
// tearing a frame. After each load, o_pov_stable is held low for
// SETTLE_CYCLES cycles so the tracer sees the new vectors only once
// they have settled.
//
// Optional feature macro: POV_SCHED_DEMO_EN
//   defined   : demo buttons are synchronised, and a frame divider gates
//               o_inc_px / o_inc_py to one update every DEMO_DIV loads.
//   undefined : o_inc_px / o_inc_py are tied to 0 and the buttons are ignored.
//
// Ports
//   clk             system clock (the only clock)
//   reset           synchronous, active-high reset
//   i_vsync         raw vsync level, asynchronous
//   i_demo_px/py    raw demo buttons, asynchronous
//   i_trace_busy    tracer is mid-row and reading POV
//   o_load_if_ready one-cycle load strobe to the POV block
//   o_inc_px/py     increment requests, valid only with o_load_if_ready
//   o_pov_stable    tracer may start a new row
//   o_frame_count   completed loads, wraps at 256
//   o_overrun       sticky: a vsync rise was dropped
module p08_pov_sched #(
    parameter int DEMO_DIV      = 4,   // 1..15
    parameter int SETTLE_CYCLES = 2    // 1..7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_vsync,
    input  logic       i_demo_px,
    input  logic       i_demo_py,
    input  logic       i_trace_busy,
    output logic       o_load_if_ready,
    output logic       o_inc_px,
    output logic       o_inc_py,
    output logic       o_pov_stable,
    output logic [7:0] o_frame_count,
    output logic       o_overrun
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_IDLE = 2'd1,
        LOAD      = 2'd2,
        SETTLE    = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] vs_sync;
    logic       vs_rise;
    logic [2:0] settle_cnt;

    // vsync synchroniser; the rise flag is registered so the FSM acts on it
    // one edge after stages [2:1] show 01.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_sync <= 3'b000;
            vs_rise <= 1'b0;
        end else begin
            vs_sync <= {vs_sync[1:0], i_vsync};
            vs_rise <= (vs_sync[2:1] == 2'b01);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:       if (vs_rise) state_nxt = i_trace_busy ? WAIT_IDLE : LOAD;
            WAIT_IDLE: if (!i_trace_busy) state_nxt = LOAD;
            LOAD:      state_nxt = SETTLE;
            SETTLE:    if (settle_cnt == 3'd0) state_nxt = RUN;
            default:   state_nxt = RUN;
        endcase
    end

    // Outputs are registered from the next-state value, so they are exact
    // decodes of the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            settle_cnt      <= 3'd0;
            o_load_if_ready <= 1'b0;
            o_pov_stable    <= 1'b1;
            o_frame_count   <= 8'd0;
            o_overrun       <= 1'b0;
        end else begin
            state           <= state_nxt;
            o_load_if_ready <= (state_nxt == LOAD);
            o_pov_stable    <= (state_nxt == RUN);
            if (state == LOAD) begin
                settle_cnt    <= 3'(SETTLE_CYCLES - 1);
                o_frame_count <= o_frame_count + 8'd1;
            end else if (state == SETTLE && settle_cnt != 3'd0) begin
                settle_cnt <= settle_cnt - 3'd1;
            end
            // A rise outside RUN has nowhere to go: drop it and flag it.
            if (vs_rise && state != RUN)
                o_overrun <= 1'b1;
        end
    end

`ifdef POV_SCHED_DEMO_EN
    logic [1:0] px_sync, py_sync;
    logic [3:0] demo_div;

    always_ff @(posedge clk) begin
        if (reset) begin
            px_sync  <= 2'b00;
            py_sync  <= 2'b00;
            demo_div <= 4'(DEMO_DIV - 1);
        end else begin
            px_sync <= {px_sync[0], i_demo_px};
            py_sync <= {py_sync[0], i_demo_py};
            if (state == LOAD)
                demo_div <= (demo_div == 4'd0) ? 4'(DEMO_DIV - 1) : demo_div - 4'd1;
        end
    end

    assign o_inc_px = (state == LOAD) && (demo_div == 4'd0) && px_sync[1];
    assign o_inc_py = (state == LOAD) && (demo_div == 4'd0) && py_sync[1];
`else
    logic unused_demo;
    assign unused_demo = &{1'b0, i_demo_px, i_demo_py};
    assign o_inc_px    = 1'b0;
    assign o_inc_py    = 1'b0;
`endif

endmodule
